// File: rtl/icache_pkg.sv
// Shared types and address helpers for the direct-mapped instruction cache.
package icache_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MISS   = 2'd1,
    REFILL = 2'd2
  } state_e;

  localparam int LINE_W     = 64;
  localparam int OFFSET_W   = 3;
  localparam int MAX_ADDR_W = 64;

  // Line index: the IDX_W bits just above the byte offset within a line.
  function automatic logic [MAX_ADDR_W-1:0] get_index(input logic [MAX_ADDR_W-1:0] addr,
                                                      input int idx_w);
    logic [MAX_ADDR_W-1:0] mask;
    mask = (MAX_ADDR_W'(1) << idx_w) - MAX_ADDR_W'(1);
    return (addr >> OFFSET_W) & mask;
  endfunction

  function automatic logic [MAX_ADDR_W-1:0] get_tag(input logic [MAX_ADDR_W-1:0] addr,
                                                    input int idx_w);
    return addr >> (OFFSET_W + idx_w);
  endfunction

endpackage

// File: rtl/icache_array.sv
// Valid/tag/data storage for icache_dm: asynchronous read, synchronous write,
// single-cycle clear of every valid bit on flush (flush beats a same-cycle write).
module icache_array
  import icache_pkg::*;
#(
  parameter int LINES = 64,
  parameter int IDX_W = 6,
  parameter int TAG_W = 23
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [IDX_W-1:0]  rd_index,
  output logic              rd_valid,
  output logic [TAG_W-1:0]  rd_tag,
  output logic [LINE_W-1:0] rd_data,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_index,
  input  logic [TAG_W-1:0]  wr_tag,
  input  logic [LINE_W-1:0] wr_data,
  input  logic              flush
);

  logic [LINES-1:0]  valid_q;
  logic [LINES-1:0]  valid_d;
  logic [TAG_W-1:0]  tag_q  [LINES];
  logic [LINE_W-1:0] data_q [LINES];

  always_comb begin
    valid_d = valid_q;
    if (flush) begin
      valid_d = '0;
    end else if (wr_en) begin
      valid_d[wr_index] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
    end
  end

  // Tag and data carry no reset; a line is only trusted through its valid bit.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_q[wr_index]  <= wr_tag;
      data_q[wr_index] <= wr_data;
    end
  end

  assign rd_valid = valid_q[rd_index];
  assign rd_tag   = tag_q[rd_index];
  assign rd_data  = data_q[rd_index];

endmodule

// File: rtl/icache_dm.sv
// Direct-mapped instruction cache: 0-cycle hits, edge-triggered line refill.
// Optional perf counters are built when ICACHE_PERF_EN is defined.
module icache_dm
  import icache_pkg::*;
#(
  parameter int LINES  = 64,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] pc,
  input  logic              fetch_req,
  input  logic              flush,
  output logic [31:0]       instr,
  output logic              instr_valid,
  output logic              stall,
  output logic [ADDR_W-1:0] iaddr,
  output logic              imiss,
  input  logic [LINE_W-1:0] data,
  input  logic              ifill,
  output logic [31:0]       hit_count,
  output logic [31:0]       miss_count,
  output state_e            state_dbg
);

  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = ADDR_W - OFFSET_W - IDX_W;

  // Handshake: imiss stays high with iaddr stable until a rising edge of ifill
  // is seen while in MISS; that cycle's data is the line. A level-high ifill
  // never counts twice.

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   miss_addr_q, miss_addr_d;
  logic                ifill_q;

  logic [IDX_W-1:0]    pc_index;
  logic [TAG_W-1:0]    pc_tag;
  logic [IDX_W-1:0]    fill_index;
  logic [TAG_W-1:0]    fill_tag;
  logic                rd_valid;
  logic [TAG_W-1:0]    rd_tag;
  logic [LINE_W-1:0]   rd_data;
  logic                hit;
  logic                fill_accept;
  logic                wr_en;

  assign pc_index   = IDX_W'(get_index(MAX_ADDR_W'(pc), IDX_W));
  assign pc_tag     = TAG_W'(get_tag(MAX_ADDR_W'(pc), IDX_W));
  assign fill_index = IDX_W'(get_index(MAX_ADDR_W'(miss_addr_q), IDX_W));
  assign fill_tag   = TAG_W'(get_tag(MAX_ADDR_W'(miss_addr_q), IDX_W));

  icache_array #(
    .LINES (LINES),
    .IDX_W (IDX_W),
    .TAG_W (TAG_W)
  ) u_array (
    .clk      (clk),
    .rst_n    (rst_n),
    .rd_index (pc_index),
    .rd_valid (rd_valid),
    .rd_tag   (rd_tag),
    .rd_data  (rd_data),
    .wr_en    (wr_en),
    .wr_index (fill_index),
    .wr_tag   (fill_tag),
    .wr_data  (data),
    .flush    (flush)
  );

  assign hit         = fetch_req & rd_valid & (rd_tag == pc_tag);
  assign fill_accept = (state_q == MISS) & ifill & ~ifill_q;

  always_comb begin
    state_d     = state_q;
    miss_addr_d = miss_addr_q;
    instr_valid = 1'b0;
    stall       = 1'b0;
    imiss       = 1'b0;
    wr_en       = 1'b0;
    case (state_q)
      IDLE: begin
        if (fetch_req) begin
          if (hit) begin
            instr_valid = 1'b1;
          end else begin
            stall       = 1'b1;
            miss_addr_d = {pc[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
            state_d     = MISS;
          end
        end
      end
      MISS: begin
        imiss = 1'b1;
        stall = 1'b1;
        if (fill_accept) begin
          // A coincident flush drops the incoming line and restarts the lookup.
          wr_en   = ~flush;
          state_d = flush ? IDLE : REFILL;
        end
      end
      REFILL: begin
        stall   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (!rst_n) begin
      instr_valid = 1'b0;
      stall       = 1'b0;
      imiss       = 1'b0;
      wr_en       = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      miss_addr_q <= '0;
      ifill_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      miss_addr_q <= miss_addr_d;
      ifill_q     <= ifill;
    end
  end

  assign instr     = !rst_n ? 32'd0 : (pc[2] ? rd_data[63:32] : rd_data[31:0]);
  assign iaddr     = miss_addr_q;
  assign state_dbg = state_q;

`ifdef ICACHE_PERF_EN
  logic        refill_done_q, refill_done_d;
  logic [31:0] hit_count_q, hit_count_d;
  logic [31:0] miss_count_q, miss_count_d;

  // The re-lookup that completes a refill belongs to that miss, not a new hit.
  always_comb begin
    refill_done_d = (state_q == REFILL);
    hit_count_d   = hit_count_q;
    miss_count_d  = miss_count_q;
    if ((state_q == IDLE) && hit && !refill_done_q) begin
      hit_count_d = hit_count_q + 32'd1;
    end
    if ((state_q == IDLE) && fetch_req && !hit) begin
      miss_count_d = miss_count_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      refill_done_q <= 1'b0;
      hit_count_q   <= '0;
      miss_count_q  <= '0;
    end else begin
      refill_done_q <= refill_done_d;
      hit_count_q   <= hit_count_d;
      miss_count_q  <= miss_count_d;
    end
  end

  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;
`else
  assign hit_count  = 32'd0;
  assign miss_count = 32'd0;
`endif

endmodule

// File: tb/tb_icache_dm.sv
// Self-checking bench for icache_dm: directed scenarios plus randomized fetches
// against a line-level model of a direct-mapped cache and a hashed backing memory.
module tb_icache_dm;
  import icache_pkg::*;

  localparam int LINES  = 64;
  localparam int ADDR_W = 32;

  logic              clk;
  logic              rst_n;
  logic [ADDR_W-1:0] pc;
  logic              fetch_req;
  logic              flush;
  logic [31:0]       instr;
  logic              instr_valid;
  logic              stall;
  logic [ADDR_W-1:0] iaddr;
  logic              imiss;
  logic [63:0]       data;
  logic              ifill;
  logic [31:0]       hit_count;
  logic [31:0]       miss_count;
  state_e            state_dbg;

  icache_dm #(.LINES(LINES), .ADDR_W(ADDR_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pc          (pc),
    .fetch_req   (fetch_req),
    .flush       (flush),
    .instr       (instr),
    .instr_valid (instr_valid),
    .stall       (stall),
    .iaddr       (iaddr),
    .imiss       (imiss),
    .data        (data),
    .ifill       (ifill),
    .hit_count   (hit_count),
    .miss_count  (miss_count),
    .state_dbg   (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  logic [31:0] exp_q[$];
  logic [31:0] miss_q[$];
  int n_cmp = 0;
  int n_err = 0;

  // Reference model: which memory line each cache slot holds.
  bit          mv    [LINES];
  logic [28:0] mline [LINES];
  int          hits_m;
  int          misses_m;

  // Memory responder knobs.
  bit          rsp_manual = 1'b0;
  logic        man_ifill  = 1'b0;
  logic [63:0] man_data   = '0;
  int          mem_lat    = 1;

  function automatic logic [63:0] mem_word(input logic [28:0] ln);
    logic [31:0] a;
    if (ln == 29'h20) return 64'h11112222_33334444;
    a = {3'b000, ln};
    return {a * 32'h9E3779B1, ~a ^ 32'h5A5A1234};
  endfunction

  function automatic logic [31:0] pick(input logic [28:0] ln, input logic hi);
    logic [63:0] w;
    w = mem_word(ln);
    return hi ? w[63:32] : w[31:0];
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_clear();
    foreach (mv[i]) mv[i] = 1'b0;
  endtask

  // ---------------- memory responder ----------------
  initial begin : mem_resp
    int  lat;
    bit  sent;
    lat  = 0;
    sent = 1'b0;
    ifill = 1'b0;
    data  = '0;
    forever begin
      @(posedge clk);
      #2;
      if (rsp_manual) begin
        ifill = man_ifill;
        data  = man_data;
        lat   = 0;
        sent  = 1'b0;
      end else begin
        ifill = 1'b0;
        if (!imiss) begin
          sent = 1'b0;
          lat  = 0;
        end else if (!sent) begin
          lat++;
          if (lat >= mem_lat) begin
            ifill = 1'b1;
            data  = mem_word(iaddr[31:3]);
            sent  = 1'b1;
            lat   = 0;
          end
        end
      end
    end
  end

  // ---------------- monitor ----------------
  logic imiss_prev = 1'b0;
  always @(negedge clk) begin
    if (rst_n) begin
      if (instr_valid) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_instr: got %0h expected no response", instr);
        end else begin
          chk("instr", instr, exp_q.pop_front());
        end
      end
      if (imiss && !imiss_prev) begin
        if (miss_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_imiss: got iaddr %0h expected no request", iaddr);
        end else begin
          chk("iaddr", iaddr, miss_q.pop_front());
        end
      end
    end
    imiss_prev = imiss;
  end

  // ---------------- driver tasks ----------------
  task automatic apply_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    fetch_req = 1'b1;
    pc = 32'h100;
    flush = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_instr_valid", instr_valid, 1'b0);
    chk("rst_stall", stall, 1'b0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_imiss", imiss, 1'b0);
    chk("rst_iaddr", iaddr, 32'd0);
    chk("rst_state", state_dbg, IDLE);
    chk("rst_hit_count", hit_count, 32'd0);
    chk("rst_miss_count", miss_count, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    fetch_req = 1'b0;
    model_clear();
    hits_m = 0;
    misses_m = 0;
  endtask

  task automatic wait_imiss();
    for (int n = 0; n < 50 && !imiss; n++) @(negedge clk);
    chk("imiss_seen", imiss, 1'b1);
  endtask

  // Holds the fetch until it is served, then drops fetch_req after that edge.
  task automatic wait_served();
    for (int n = 0; n < 60 && !instr_valid; n++) @(negedge clk);
    chk("served", instr_valid, 1'b1);
    @(posedge clk);
    #1;
    fetch_req = 1'b0;
  endtask

  task automatic do_fetch(input logic [31:0] a);
    logic [28:0] ln;
    int          idx;
    bit          h;
    ln  = a[31:3];
    idx = int'(ln) % LINES;
    h   = mv[idx] && (mline[idx] == ln);
    if (h) begin
      hits_m++;
    end else begin
      miss_q.push_back({ln, 3'b000});
      misses_m++;
      mv[idx]    = 1'b1;
      mline[idx] = ln;
    end
    exp_q.push_back(pick(ln, a[2]));
    mem_lat = $urandom_range(1, 4);
    @(posedge clk);
    #1;
    pc = a;
    fetch_req = 1'b1;
    @(negedge clk);
    chk("lookup_valid", instr_valid, h);
    chk("lookup_stall", stall, !h);
    if (h) chk("hit_no_imiss", imiss, 1'b0);
    wait_served();
  endtask

  task automatic flush_pulse();
    @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    model_clear();
  endtask

  task automatic chk_perf();
    @(negedge clk);
`ifdef ICACHE_PERF_EN
    chk("hit_count", hit_count, 32'(hits_m));
    chk("miss_count", miss_count, 32'(misses_m));
`else
    chk("hit_count", hit_count, 32'd0);
    chk("miss_count", miss_count, 32'd0);
`endif
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst_n = 1'b0;
    fetch_req = 1'b0;
    flush = 1'b0;
    pc = '0;
    hits_m = 0;
    misses_m = 0;
    apply_reset();

    // Cold miss then hits on both halves of the line.
    do_fetch(32'h100);
    do_fetch(32'h104);
    do_fetch(32'h100);
    chk_perf();

    // Conflict eviction: 0x100 and 0x300 share index 0x20.
    do_fetch(32'h300);
    do_fetch(32'h100);
    do_fetch(32'h304);

    // Flush then refetch misses.
    flush_pulse();
    do_fetch(32'h100);

    // Flush coincident with the fill edge: line dropped, fetch misses again.
    flush_pulse();
    rsp_manual = 1'b1;
    man_ifill  = 1'b0;
    miss_q.push_back(32'h100);
    miss_q.push_back(32'h100);
    misses_m += 2;
    exp_q.push_back(pick(29'h20, 1'b0));
    mv[32]    = 1'b1;
    mline[32] = 29'h20;
    @(posedge clk);
    #1;
    pc = 32'h100;
    fetch_req = 1'b1;
    wait_imiss();
    @(posedge clk);
    #1;
    flush = 1'b1;
    man_ifill = 1'b1;
    man_data = mem_word(29'h20);
    @(posedge clk);
    #1;
    flush = 1'b0;
    man_ifill = 1'b0;
    rsp_manual = 1'b0;
    mem_lat = 2;
    @(negedge clk);
    chk("flush_win_state", state_dbg, IDLE);
    chk("flush_win_stall", stall, 1'b1);
    chk("flush_win_valid", instr_valid, 1'b0);
    wait_served();

    // Level ifill: held high after a fill, a new miss waits for a fresh edge.
    flush_pulse();
    rsp_manual = 1'b1;
    man_ifill = 1'b0;
    miss_q.push_back(32'h180);
    exp_q.push_back(pick(29'h30, 1'b0));
    misses_m++;
    mv[48] = 1'b1;
    mline[48] = 29'h30;
    @(posedge clk);
    #1;
    pc = 32'h180;
    fetch_req = 1'b1;
    wait_imiss();
    @(posedge clk);
    #1;
    man_ifill = 1'b1;
    man_data = mem_word(29'h30);
    wait_served();
    miss_q.push_back(32'h200);
    exp_q.push_back(pick(29'h40, 1'b0));
    misses_m++;
    mv[0] = 1'b1;
    mline[0] = 29'h40;
    pc = 32'h200;
    fetch_req = 1'b1;
    wait_imiss();
    repeat (4) begin
      @(negedge clk);
      chk("level_imiss", imiss, 1'b1);
      chk("level_stall", stall, 1'b1);
    end
    @(posedge clk);
    #1;
    man_ifill = 1'b0;
    @(posedge clk);
    #1;
    man_ifill = 1'b1;
    man_data = mem_word(29'h40);
    @(posedge clk);
    #1;
    man_ifill = 1'b0;
    wait_served();
    rsp_manual = 1'b0;
    do_fetch(32'h184);

    // Reset in the middle of a miss; a late ifill must not install anything.
    flush_pulse();
    rsp_manual = 1'b1;
    man_ifill = 1'b0;
    miss_q.push_back(32'h100);
    @(posedge clk);
    #1;
    pc = 32'h100;
    fetch_req = 1'b1;
    wait_imiss();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    fetch_req = 1'b0;
    @(negedge clk);
    chk("midrst_stall", stall, 1'b0);
    chk("midrst_valid", instr_valid, 1'b0);
    chk("midrst_instr", instr, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    man_ifill = 1'b1;
    man_data = 64'hDEADBEEF_CAFEF00D;
    @(negedge clk);
    chk("midrst_imiss", imiss, 1'b0);
    chk("midrst_stall_after", stall, 1'b0);
    chk("midrst_state", state_dbg, IDLE);
    @(posedge clk);
    #1;
    man_ifill = 1'b0;
    rsp_manual = 1'b0;
    model_clear();
    hits_m = 0;
    misses_m = 0;
    do_fetch(32'h100);

    // Counter scenario from a clean reset.
    apply_reset();
    do_fetch(32'h100);
    do_fetch(32'h104);
    do_fetch(32'h100);
    chk_perf();

    // Randomized fetches over a small footprint to mix hits and conflicts.
    for (int i = 0; i < 160; i++) begin
      logic [31:0] a;
      a = (32'($urandom_range(0, 3)) << 9) | (32'($urandom_range(0, 7)) << 3) |
          (32'($urandom_range(0, 1)) << 2);
      if ($urandom_range(0, 15) == 0) flush_pulse();
      do_fetch(a);
    end
    chk_perf();

    repeat (5) @(negedge clk);
    chk("exp_q_drained", 64'(exp_q.size()), 64'd0);
    chk("miss_q_drained", 64'(miss_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/icache_dm.md
Name: icache_dm

Overview:
- Direct-mapped instruction cache between the fetch stage and the shared memory block.
- Serves 32-bit instructions to fetch from 64-bit lines.
- On a miss it drives the memory request side (iaddr/imiss) and installs the 64-bit line returned with the ifill strobe.
- It is the immediate upstream client of memory on the instruction port.

Parameters:
- LINES, 64, number of cache lines; power of two, min 2.
- ADDR_W, 32, byte-address width.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- pc  in  ADDR_W  fetch byte address; bits [1:0] ignored.
- fetch_req  in  1  fetch request this cycle.
- flush  in  1  invalidate all lines.
- instr  out  32  fetched instruction.
- instr_valid  out  1  instr valid this cycle.
- stall  out  1  fetch must hold pc and fetch_req.
- iaddr  out  ADDR_W  line address to memory; bits [2:0] always 0.
- imiss  out  1  refill request to memory.
- data  in  64  line from memory; byte 0 at bits [7:0].
- ifill  in  1  fill strobe from memory (level signal; see below).
- hit_count  out  32  perf counter (see Optional Feature).
- miss_count  out  32  perf counter (see Optional Feature).

Behaviour:
- Address split:
  - offset = pc[2:0].
  - index = pc[2+IDX_W:3], where IDX_W = log2(LINES).
  - tag = pc[ADDR_W-1:3+IDX_W].
  - instr = line[31:0] if pc[2]=0, else line[63:32].
- Storage: per-line valid bit, tag and 64-bit data. Asynchronous read, synchronous write.
- FSM states: IDLE, MISS, REFILL.
- IDLE:
  - hit = fetch_req & valid[index] & (tag match).
  - On hit: instr_valid=1 and stall=0, combinational in the same cycle (0-cycle latency).
  - On fetch_req & !hit: stall=1 and instr_valid=0 in the same cycle; latch miss_addr={pc[ADDR_W-1:3],3'b0}; next state MISS.
  - With no fetch_req: instr_valid=0, stall=0.
- MISS:
  - imiss=1, iaddr=miss_addr, stall=1.
  - Fill accepted only on an ifill rising edge: ifill=1 and ifill_q=0, where ifill_q is ifill registered, reset to 0.
  - On acceptance: write data, tag and valid=1 to the line; imiss deasserts next cycle; next state REFILL.
  - ifill held high continuously is never re-accepted.
- REFILL: stall=1 for one cycle, then IDLE. The re-lookup then hits.
- Miss penalty: memory latency + 2 cycles.
- pc must be held while stall=1. If pc changes anyway, the latched miss_addr line is still filled and the lookup is re-evaluated in IDLE.
- flush:
  - Clears all valid bits at the next edge.
  - If flush coincides with fill acceptance, flush wins: the line is not installed and the next state is IDLE.
  - Flush in MISS without a fill: valid bits cleared, the miss continues.
- Reset: state=IDLE, all valid=0, imiss=0, iaddr=0, ifill_q=0, counters=0; instr_valid=0, stall=0, instr=0 while rst_n=0.
- Reset mid-MISS: the request is abandoned and imiss=0 after the reset edge. A late ifill is ignored outside MISS.
- Tag and data contents need no reset.

Optional Feature:
- Macro ICACHE_PERF_EN.
- Defined:
  - hit_count increments on each IDLE hit.
  - miss_count increments on each IDLE→MISS transition.
  - Both are 32-bit, wrap at 2^32-1→0, and are cleared by reset only (not flush).
- Undefined: both ports are tied to 0 and the counters are not synthesised.

Decomposition:
- Package icache_pkg holds:
  - state enum {IDLE, MISS, REFILL};
  - LINE_W=64;
  - OFFSET_W=3;
  - index and tag extraction functions parameterised by IDX_W.
- Sub-module icache_array (valid, tag and data storage; async read, sync write, single-cycle flush clear) is natural. The FSM, ifill edge detect and counters stay in icache_dm.

Test Plan:
- Cold miss then hit: after reset, pc=0x100 with fetch_req; memory returns 0x11112222_33334444.
  - Required: imiss=1 with iaddr=0x100 and stall=1 until the fill.
  - Then instr=0x33334444 with instr_valid.
  - Then pc=0x104 gives instr=0x11112222 in the same cycle, with no imiss.
- Conflict eviction (LINES=64): fill 0x100, then fetch 0x300 (same index 0x20).
  - Required: 0x300 misses and installs.
  - Refetching 0x100 misses again with iaddr=0x100.
- Flush: fill 0x100, pulse flush, fetch 0x100 → miss, imiss=1. Separately, flush coincident with the ifill edge → line not installed and the next fetch misses.
- Level ifill: memory holds ifill=1 after the first fill; a second miss at 0x200.
  - Required: no fill is accepted until ifill goes 0 then 1; imiss stays 1 meanwhile.
- Reset mid-MISS: assert rst_n=0 while imiss=1.
  - Required: imiss=0, stall=0 after the edge; fetch 0x100 misses afresh.
- With ICACHE_PERF_EN: fetch 0x100 (miss), 0x104, 0x100 → hit_count=2, miss_count=1. Without the macro, both read 0.
